// File: rtl/autosym_expander.sv
// Autosymmetric expander: evaluates f(x) = f_red(A*x) over GF(2) through a
// two-stage valid/ready pipeline. The matrix A and the f_red truth table are loaded while in CFG.
module autosym_expander #(
    parameter int unsigned N_IN  = 15,
    parameter int unsigned K_RED = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [K_RED-1:0] cfg_addr,
    input  logic [N_IN-1:0]  cfg_data,
    input  logic             cfg_done,
    input  logic             cfg_start,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_f,
    output logic [K_RED-1:0] out_idx,
    output logic [CNT_W-1:0] eval_count,
    output logic [1:0]       state_o
);

    localparam int unsigned TT_N  = 1 << K_RED;
    localparam int unsigned ROW_W = (K_RED > 1) ? $clog2(K_RED) : 1;

    typedef enum logic [1:0] {
        ST_CFG   = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   mat_q [K_RED];
    logic [TT_N-1:0]   tt_q;
    logic              s1_valid_q, s2_valid_q;
    logic [K_RED-1:0]  s1_idx_q, s1_idx_d;
    logic              out_f_q;
    logic [K_RED-1:0]  out_idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cfg_err_q;
    logic              accept, s1_advance, row_ok, wr_ok, wr_bad;

    assign row_ok     = cfg_addr < K_RED'(K_RED);
    assign wr_ok      = cfg_we && (state_q == ST_CFG) && (cfg_sel || row_ok);
    assign wr_bad     = cfg_we && !wr_ok;
    assign s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready   = (state_q == ST_RUN) && (!s1_valid_q || s1_advance);
    assign accept     = in_valid && in_ready;

    // Mode FSM; DRAIN waits for both pipeline stages to empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CFG:   if (cfg_done) state_d = ST_RUN;
            ST_RUN:   if (cfg_start) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_CFG;
            default:  state_d = ST_CFG;
        endcase
    end

    // Reduced address: each bit is the parity of the input masked by one matrix row.
    always_comb begin
        s1_idx_d = '0;
        for (int j = 0; j < K_RED; j++) begin
            s1_idx_d[j] = ^(in_x & mat_q[j]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CFG;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= wr_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < K_RED; j++) begin
                mat_q[j] <= '0;
            end
            tt_q <= '0;
        end else if (wr_ok) begin
            if (cfg_sel) begin
                tt_q[cfg_addr] <= cfg_data[0];
            end else begin
                mat_q[cfg_addr[ROW_W-1:0]] <= cfg_data;
            end
        end
    end

    // Stage 2 only loads when it is empty or its current result is being taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            out_f_q    <= 1'b0;
            out_idx_q  <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_idx_q   <= s1_idx_d;
            end else if (s1_advance) begin
                s1_valid_q <= 1'b0;
            end
            if (s1_advance) begin
                s2_valid_q <= 1'b1;
                out_f_q    <= tt_q[s1_idx_q];
                out_idx_q  <= s1_idx_q;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (s2_valid_q && out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cfg_err    = cfg_err_q;
    assign out_valid  = s2_valid_q;
    assign out_f      = out_f_q;
    assign out_idx    = out_idx_q;
    assign eval_count = cnt_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_autosym_expander.sv
// Scoreboard bench for autosym_expander: the driver queues expected results when a
// vector is accepted, and a monitor pops and compares them on every output handshake.
module tb_autosym_expander;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we, cfg_sel, cfg_done, cfg_start;
    logic [7:0]  cfg_addr;
    logic [14:0] cfg_data;
    logic        cfg_err;
    logic        in_valid, in_ready;
    logic [14:0] in_x;
    logic        out_valid, out_ready, out_f;
    logic [7:0]  out_idx;
    logic [15:0] eval_count;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    autosym_expander dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_done(cfg_done), .cfg_start(cfg_start), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_idx(out_idx),
        .eval_count(eval_count), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled well after the falling edge, ahead of the handshake edge.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {23'd0, out_f, out_idx}, 32'h1ff);
            end else begin
                chk("result_f_idx", {23'd0, out_f, out_idx}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cfg_write(input logic sel, input logic [7:0] addr, input logic [14:0] data,
                             input logic exp_err);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
        #1 chk("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
    endtask

    task automatic go_run();
        @(negedge clk); cfg_done = 1'b1;
        @(negedge clk); cfg_done = 1'b0;
        #1 chk("state_run", {30'd0, state_o}, 32'd1);
    endtask

    // Call at a falling edge; returns at the falling edge after acceptance with in_valid still high.
    task automatic send(input logic [14:0] x, input logic f, input logic [7:0] idx);
        int n = 0;
        in_valid = 1'b1; in_x = x;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        else exp_q.push_back({f, idx});
        @(negedge clk);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk); n++;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic to_cfg();
        int n = 0;
        @(negedge clk); cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        while (state_o != 2'b00 && n < 20) begin
            @(negedge clk); n++;
        end
        chk("state_cfg", {30'd0, state_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
        cfg_done = 0; cfg_start = 0; in_valid = 0; in_x = 0; out_ready = 0;
        #22;
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_eval_count", {16'd0, eval_count}, 32'd0);
        chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Identity matrix with tt[5] = 1
        for (int j = 0; j < 8; j++) cfg_write(1'b0, 8'(j), 15'(1 << j), 1'b0);
        cfg_write(1'b1, 8'd5, 15'd1, 1'b0);
        go_run();
        out_ready = 1'b1;
        @(negedge clk);
        send(15'h0005, 1'b1, 8'h05);
        in_valid = 1'b0;
        #1 chk("latency_t1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1 chk("latency_t2", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        send(15'h0006, 1'b0, 8'h06);
        in_valid = 1'b0;
        wait_empty();
        chk("count_identity", {16'd0, eval_count}, 32'd2);

        // Parity row over all 15 input bits
        to_cfg();
        cfg_write(1'b0, 8'd0, 15'h7fff, 1'b0);
        for (int j = 1; j < 8; j++) cfg_write(1'b0, 8'(j), 15'h0000, 1'b0);
        go_run();
        @(negedge clk);
        send(15'h0003, 1'b0, 8'h00);
        send(15'h0007, 1'b0, 8'h01);
        send(15'h4000, 1'b0, 8'h01);
        in_valid = 1'b0;
        wait_empty();
        chk("count_parity", {16'd0, eval_count}, 32'd5);

        // Backpressure: two held, then four results back-to-back
        out_ready = 1'b0;
        @(negedge clk);
        send(15'h0001, 1'b0, 8'h01);
        send(15'h0003, 1'b0, 8'h00);
        in_x = 15'h7fff;
        #1 chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        #1 chk("bp_still_low", {31'd0, in_ready}, 32'd0);
        chk("bp_held_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        send(15'h7fff, 1'b0, 8'h01);
        send(15'h0000, 1'b0, 8'h00);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("bp_count_no_bubble", {16'd0, eval_count}, 32'd9);
        wait_empty();

        // Config protection
        to_cfg();
        for (int j = 0; j < 8; j++) cfg_write(1'b0, 8'(j), 15'(1 << j), 1'b0);
        cfg_write(1'b0, 8'd9, 15'h7fff, 1'b1);
        @(negedge clk);
        #1 chk("cfg_err_pulse_end", {31'd0, cfg_err}, 32'd0);
        go_run();
        cfg_write(1'b1, 8'd5, 15'd0, 1'b1);
        @(negedge clk);
        send(15'h0005, 1'b1, 8'h05);
        in_valid = 1'b0;
        wait_empty();
        chk("count_protect", {16'd0, eval_count}, 32'd10);

        // Drain with two vectors held
        out_ready = 1'b0;
        @(negedge clk);
        send(15'h0005, 1'b1, 8'h05);
        send(15'h0003, 1'b0, 8'h03);
        in_valid = 1'b0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        in_valid = 1'b1; in_x = 15'h0001;
        #1 chk("drain_state", {30'd0, state_o}, 32'd2);
        chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_empty();
        begin
            int n = 0;
            while (state_o != 2'b00 && n < 20) begin
                @(negedge clk); n++;
            end
        end
        chk("drain_to_cfg", {30'd0, state_o}, 32'd0);
        chk("count_drain", {16'd0, eval_count}, 32'd12);

        // Asynchronous reset with both stages full
        go_run();
        out_ready = 1'b0;
        @(negedge clk);
        send(15'h0005, 1'b1, 8'h05);
        send(15'h0006, 1'b0, 8'h06);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_eval_count", {16'd0, eval_count}, 32'd0);
        chk("arst_state", {30'd0, state_o}, 32'd0);
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        go_run();
        out_ready = 1'b1;
        @(negedge clk);
        send(15'h0005, 1'b0, 8'h00);
        in_valid = 1'b0;
        wait_empty();
        chk("count_after_rst", {16'd0, eval_count}, 32'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/autosym_expander.md
Name: autosym_expander

Overview:
- Sequential evaluator for the expanded side of an autosymmetric D-reduction. Given a loaded projection matrix and the reduced function's truth table, it computes f(x) = f_red(A·x) over GF(2) for a stream of N_IN-bit input vectors.
- Used in the benchmark harness to regenerate full-function outputs from reduced forms, so they can be checked against the optimized combinational netlists.
- Config interface, valid/ready input stream, 2-stage pipeline, valid/ready output stream.

Parameters:
- N_IN, 15, input vector width
- K_RED, 8, number of reduced variables; the truth table holds 2^K_RED bits
- CNT_W, 16, width of the evaluation counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = write matrix row, 1 = write truth-table bit
- cfg_addr  in  K_RED  matrix row index or truth-table address
- cfg_data  in  N_IN  matrix row mask; bit 0 is the TT bit
- cfg_done  in  1  leave CFG and enter RUN
- cfg_start  in  1  request return to CFG (drains first)
- cfg_err  out  1  1-cycle pulse on a rejected config write
- in_valid  in  1  input vector valid
- in_ready  out  1  input accepted when high with in_valid
- in_x  in  N_IN  input vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_f  out  1  f(x)
- out_idx  out  K_RED  reduced address A·x, for debug
- eval_count  out  CNT_W  output handshakes since reset, saturating
- state_o  out  2  00 CFG, 01 RUN, 10 DRAIN

Behaviour:
- Reset (async, any time, including mid-stream):
  - state = CFG.
  - Matrix rows, TT bits, pipeline valids, out_f, out_idx, eval_count and cfg_err all go to 0.
  - In-flight vectors are discarded.
- FSM:
  - CFG -> RUN on cfg_done.
  - RUN -> DRAIN on cfg_start.
  - DRAIN -> CFG in the first cycle in which both stage valids are 0.
  - cfg_done outside CFG is ignored. cfg_start outside RUN is ignored.
- Config writes:
  - Honoured only in CFG.
  - cfg_sel=0 with cfg_addr < K_RED: mat[cfg_addr] <= cfg_data.
  - cfg_sel=1: tt[cfg_addr] <= cfg_data[0].
  - cfg_we outside CFG, or with cfg_sel=0 and cfg_addr >= K_RED: no state change, and cfg_err pulses high for the next cycle.
  - cfg_we and cfg_done in the same cycle: the write is applied, then the FSM enters RUN.
- Input acceptance:
  - in_ready = (state==RUN) && (!s1_valid || s1_advance).
  - A vector is accepted when in_valid && in_ready.
- Stage 1: on accept, s1_idx[j] <= XOR-reduce(in_x & mat[j]) for j = 0..K_RED-1.
- Stage 2: s2 loads s1 when s1_valid && (!s2_valid || out_ready). out_f <= tt[s1_idx]; out_idx <= s1_idx.
  - out_valid = s2_valid.
  - out_f and out_idx hold stable while out_valid && !out_ready.
- Latency and throughput:
  - Accept in cycle t -> out_valid in cycle t+2 when there are no stalls.
  - Full throughput of 1 vector per cycle.
  - No bubbles are inserted under continuous out_ready.
- Backpressure:
  - With out_ready=0, at most 2 vectors are held.
  - in_ready drops only when both stages are full.
- Simultaneous accept and drain in the same cycle is legal.
- DRAIN accepts no new input but completes the held vectors normally.
- eval_count:
  - Increments on out_valid && out_ready.
  - Saturates at 2^CNT_W - 1.
  - Cleared only by rst.

Test Plan:
- Identity load: in CFG, write mat[j] = 1<<j for j = 0..7 and tt[5] = 1, then cfg_done. Send in_x = 0x0005 -> at t+2, out_f=1, out_idx=0x05. Send in_x = 0x0006 -> out_f=0, out_idx=0x06.
- Parity row: write mat[0] = 0x7FFF and mat[1..7] = 0. Send in_x = 0x0003 -> out_idx=0x00. Send in_x = 0x0007 -> out_idx=0x01. Upper bits of in_x above K_RED also affect parity: in_x = 0x4000 -> out_idx=0x01.
- Backpressure: send 4 back-to-back vectors with out_ready=0 -> in_ready=0 after 2 accepts. Raise out_ready -> all 4 results appear in order, one per cycle, with eval_count=4.
- Config protection: in RUN, issue cfg_we with cfg_sel=1, addr 5, data 0 -> cfg_err pulses and tt[5] is unchanged (a later in_x=0x0005 still gives out_f=1). In CFG, a write to mat[9] -> cfg_err pulses.
- Drain: 2 vectors in flight, out_ready=0, then cfg_start -> state_o=10 and in_ready=0. Raise out_ready -> both outputs delivered, then state_o=00.
- Reset mid-stream: assert rst asynchronously with s1 and s2 valid -> out_valid=0, eval_count=0 and state_o=00 immediately. After release, the old matrix is gone: cfg_done, then in_x=0x0005 -> out_idx=0x00, out_f=0.
